buffer_to_mpf_sm: RTL

Write-back stage of the FFT accelerator, downstream of the compute buffer. It pops result cache lines from the output buffer and issues single-line CCI-P write requests through MPF on channel 1, using virtual addresses. It counts write responses on c1Rx and reports completion only when every issued line has been acknowledged.

---
 rtl/fft_mem_pkg.sv | 114 +++++++++++
 rtl/wr_rsp_counter.sv | 30 +++
 rtl/buffer_to_mpf_sm.sv | 103 ++++++++++
 3 files changed

// File: rtl/fft_mem_pkg.sv
// Shared FFT memory-side types: state encoding, CCI-P / MPF channel-1 header and response
// structures, and the helpers used to build write headers and classify responses.
package fft_mem_pkg;

  localparam int unsigned LEN_WIDTH_DEFAULT = 64;
  localparam int unsigned CCI_CLADDR_WIDTH  = 42;
  localparam int unsigned CCI_CLDATA_WIDTH  = 512;

  typedef logic [CCI_CLADDR_WIDTH-1:0] t_cci_clAddr;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} t_sm_state;

  typedef enum logic [1:0] {
    eVC_VA  = 2'd0,
    eVC_VL0 = 2'd1,
    eVC_VH0 = 2'd2,
    eVC_VH1 = 2'd3
  } t_ccip_vc;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'b00,
    eCL_LEN_2 = 2'b01,
    eCL_LEN_4 = 2'b11
  } t_ccip_clLen;

  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h0,
    eREQ_WRLINE_M = 4'h1,
    eREQ_WRPUSH_I = 4'h2,
    eREQ_WRFENCE  = 4'h4,
    eREQ_INTR     = 4'h6
  } t_ccip_c1_req;

  typedef enum logic [3:0] {
    eRSP_WRLINE  = 4'h1,
    eRSP_WRFENCE = 4'h4,
    eRSP_INTR    = 4'h8
  } t_ccip_c1_rsp;

  typedef struct packed {
    t_ccip_vc     vc_used;
    logic         rsvd1;
    logic         hit_miss;
    logic         format;
    logic         rsvd0;
    logic [1:0]   cl_num;
    t_ccip_c1_rsp resp_type;
    logic [15:0]  mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

  typedef struct packed {
    logic        check_load_store_order;
    logic        addr_is_virtual;
    logic        map_va_to_phys_channel;
    t_ccip_vc    vc_sel;
    t_ccip_clLen cl_len;
    logic        sop;
  } t_cci_mpf_ReqMemHdrParams;

  typedef struct packed {
    logic         check_load_store_order;
    logic         addr_is_virtual;
    logic         map_va_to_phys_channel;
    t_ccip_vc     vc_sel;
    logic         sop;
    t_ccip_clLen  cl_len;
    t_ccip_c1_req req_type;
    t_cci_clAddr  address;
    logic [15:0]  mdata;
  } t_cci_mpf_c1_ReqMemHdr;

  localparam int unsigned CCI_MPF_C1TX_MEMHDR_WIDTH = $bits(t_cci_mpf_c1_ReqMemHdr);

  function automatic logic cci_c1Rx_isWriteRsp(input t_if_ccip_c1_Rx rx);
    return rx.rspValid && (rx.hdr.resp_type == eRSP_WRLINE);
  endfunction

  // Single-line virtual-address writes on the auto-selected channel.
  function automatic t_cci_mpf_ReqMemHdrParams wr_hdr_params_default();
    t_cci_mpf_ReqMemHdrParams p;
    p                 = '0;
    p.addr_is_virtual = 1'b1;
    p.vc_sel          = eVC_VA;
    p.cl_len          = eCL_LEN_1;
    p.sop             = 1'b1;
    return p;
  endfunction

  function automatic t_cci_mpf_c1_ReqMemHdr cci_mpf_c1_genReqHdr(
    input t_ccip_c1_req             req_type,
    input t_cci_clAddr              address,
    input logic [15:0]              mdata,
    input t_cci_mpf_ReqMemHdrParams params
  );
    t_cci_mpf_c1_ReqMemHdr h;
    h                        = '0;
    h.check_load_store_order = params.check_load_store_order;
    h.addr_is_virtual        = params.addr_is_virtual;
    h.map_va_to_phys_channel = params.map_va_to_phys_channel;
    h.vc_sel                 = params.vc_sel;
    h.sop                    = params.sop;
    h.cl_len                 = params.cl_len;
    h.req_type               = req_type;
    h.address                = address;
    h.mdata                  = mdata;
    return h;
  endfunction

endpackage

// File: rtl/wr_rsp_counter.sv
// Counts single-line write responses on channel 1 for the current job and flags when every
// line of the job has been acknowledged.
module wr_rsp_counter
  import fft_mem_pkg::*;
#(
  parameter int unsigned LEN_WIDTH = LEN_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 enable,
  input  t_if_ccip_c1_Rx       c1Rx,
  input  logic [LEN_WIDTH-1:0] data_length,
  output logic [LEN_WIDTH-1:0] count,
  output logic                 all_acked
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (start) begin
      count <= '0;
    end else if (enable && cci_c1Rx_isWriteRsp(c1Rx)) begin
      count <= count + LEN_WIDTH'(1);
    end
  end

  assign all_acked = (count == data_length);

endmodule

// File: rtl/buffer_to_mpf_sm.sv
// Write-back stage: pops result lines from the show-ahead output buffer, issues one MPF
// WrLine per line at consecutive virtual line addresses, and holds done low until all ack.
module buffer_to_mpf_sm
  import fft_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = CCI_CLDATA_WIDTH,
  parameter int unsigned LEN_WIDTH  = LEN_WIDTH_DEFAULT
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 run,
  input  logic [LEN_WIDTH-1:0]                 data_length,
  input  t_cci_clAddr                          first_clAddr,
  output logic                                 done,
  input  logic                                 c1TxAlmFull,
  output logic                                 c1TxValid,
  output logic [CCI_MPF_C1TX_MEMHDR_WIDTH-1:0] reqMemHdr,
  output logic [DATA_WIDTH-1:0]                reqData,
  input  t_if_ccip_c1_Rx                       c1Rx,
  input  logic [DATA_WIDTH-1:0]                buffer_data,
  input  logic                                 buffer_empty,
  output logic                                 buffer_rd_enable
);

  t_sm_state            state;
  logic [LEN_WIDTH-1:0] req_count;
  logic [LEN_WIDTH-1:0] rsp_count;
  logic                 start;
  logic                 wr_go;
  logic                 rsp_enable;
  logic                 all_acked;
  t_cci_clAddr          wr_addr;

  assign start      = (state == IDLE) && run;
  assign rsp_enable = (state == RUN) || (state == DRAIN);
  assign wr_go      = (state == RUN) && !buffer_empty && !c1TxAlmFull &&
                      (req_count < data_length);
  assign buffer_rd_enable = wr_go;

  // Line address wraps silently at the VA width.
  assign wr_addr = first_clAddr + t_cci_clAddr'(req_count);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      done      <= 1'b1;
      c1TxValid <= 1'b0;
      reqMemHdr <= '0;
      reqData   <= '0;
      req_count <= '0;
    end else begin
      c1TxValid <= wr_go;
      if (wr_go) begin
        reqData   <= buffer_data;
        reqMemHdr <= cci_mpf_c1_genReqHdr(eREQ_WRLINE_I, wr_addr, 16'h0,
                                          wr_hdr_params_default());
        req_count <= req_count + LEN_WIDTH'(1);
      end
      unique case (state)
        IDLE: begin
          if (run) begin
            state     <= RUN;
            done      <= 1'b0;
            req_count <= '0;
          end
        end
        RUN: begin
          if (req_count == data_length) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (all_acked) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          done  <= 1'b1;
        end
      endcase
    end
  end

  wr_rsp_counter #(
    .LEN_WIDTH(LEN_WIDTH)
  ) u_wr_rsp_counter (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .enable     (rsp_enable),
    .c1Rx       (c1Rx),
    .data_length(data_length),
    .count      (rsp_count),
    .all_acked  (all_acked)
  );

  // A response can never run ahead of the request it acknowledges.
  rsp_after_req_a : assert property (@(posedge clk) disable iff (reset)
    rsp_count <= req_count);

endmodule
